// File: rtl/instr_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : instr_pkg                                                    |
// | Description : Shared definitions for the decode queue: format-class        |
// |               encodings, 5-bit opcode constants and the packed record of   |
// |               decoded register/format fields stored per queue entry.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package instr_pkg;

    // Format class reported on out_type
    typedef enum logic [1:0] {
        CLS_J  = 2'd0,  // J / JAL / HALT / NOP and anything unrecognised
        CLS_I1 = 2'd1,  // 5-bit immediate forms
        CLS_I2 = 2'd2,  // 8-bit immediate forms
        CLS_R  = 2'd3   // register-register forms
    } cls_e;

    // Opcodes, instr[15:11]
    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JR    = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_JALR  = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;
    localparam logic [4:0] OP_BLTZ  = 5'b01110;
    localparam logic [4:0] OP_BGEZ  = 5'b01111;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_ROLI  = 5'b10100;
    localparam logic [4:0] OP_SLLI  = 5'b10101;
    localparam logic [4:0] OP_RORI  = 5'b10110;
    localparam logic [4:0] OP_SRLI  = 5'b10111;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_BTR   = 5'b11001;
    localparam logic [4:0] OP_SHFT  = 5'b11010;
    localparam logic [4:0] OP_ARITH = 5'b11011;
    localparam logic [4:0] OP_SEQ   = 5'b11100;
    localparam logic [4:0] OP_SLT   = 5'b11101;
    localparam logic [4:0] OP_SLE   = 5'b11110;
    localparam logic [4:0] OP_SCO   = 5'b11111;

    // Decoded fields kept per entry (immediate is stored separately because
    // its width is a parameter of the queue)
    typedef struct packed {
        cls_e       cls;
        logic [4:0] opcode;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] rd;
    } fields_t;

endpackage

`default_nettype wire

// File: rtl/instr_fields_dec.sv
// +----------------------------------------------------------------------------+
// | Module      : instr_fields_dec                                             |
// | Description : Purely combinational classifier and field extractor for one  |
// |               16-bit instruction word.                                     |
// |   instr   in  16     raw instruction                                       |
// |   cls     out 2      format class (instr_pkg::cls_e)                       |
// |   opcode  out 5      instr[15:11]                                          |
// |   rs/rt/rd out 3     register fields                                       |
// |   imm     out IMM_W  sign/zero-extended immediate                          |
// |   illegal out 1      opcode is not a defined instruction                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module instr_fields_dec
    import instr_pkg::*;
#(
    parameter int IMM_W = 16
)(
    input  logic [15:0]      instr,
    output cls_e             cls,
    output logic [4:0]       opcode,
    output logic [2:0]       rs,
    output logic [2:0]       rt,
    output logic [2:0]       rd,
    output logic [IMM_W-1:0] imm,
    output logic             illegal
);

    assign opcode = instr[15:11];
    assign rs     = instr[10:8];
    assign rt     = instr[7:5];

    always_comb begin
        cls     = CLS_J;
        imm     = '0;
        illegal = 1'b0;
        case (instr[15:11])
            OP_HALT, OP_NOP: begin
                cls = CLS_J;
            end
            OP_J, OP_JAL: begin
                imm = IMM_W'($signed(instr[10:0]));
            end
            OP_ADDI, OP_SUBI, OP_ST, OP_LD, OP_STU: begin
                cls = CLS_I1;
                imm = IMM_W'($signed(instr[4:0]));
            end
            OP_XORI, OP_ANDNI, OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
                cls = CLS_I1;
                imm = IMM_W'(instr[4:0]);
            end
            OP_SLBI: begin
                cls = CLS_I2;
                imm = IMM_W'(instr[7:0]);
            end
            OP_LBI, OP_JR, OP_JALR, OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: begin
                cls = CLS_I2;
                imm = IMM_W'($signed(instr[7:0]));
            end
            OP_BTR, OP_SHFT, OP_ARITH, OP_SEQ, OP_SLT, OP_SLE, OP_SCO: begin
                cls = CLS_R;
            end
            default: begin
                // Unknown opcodes look exactly like class 0 with a zero
                // immediate; only the illegal flag distinguishes them.
                illegal = 1'b1;
            end
        endcase
    end

    // Destination register location depends on the format
    always_comb begin
        rd = 3'd0;
        case (cls)
            CLS_R:   rd = instr[4:2];
            CLS_I1:  rd = instr[7:5];
            CLS_I2:  rd = instr[10:8];
            default: rd = 3'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instr_decode_q.sv
// +----------------------------------------------------------------------------+
// | Module      : instr_decode_q                                               |
// | Description : Decode-at-enqueue instruction queue. Each accepted 16-bit    |
// |               word is decoded once and the full decoded record is stored;  |
// |               the head record is presented directly from storage.          |
// |   clk, rst_n          clock, synchronous active-low reset                  |
// |   in_instr/valid/ready  fetch side handshake                               |
// |   flush               drop all entries, clear halt (and error) latches     |
// |   out_valid/ready     consumer handshake                                   |
// |   out_type/opcode/rs/rt/rd/imm/err  decoded head entry (0 when empty)      |
// |   halted              a HALT has been queued                               |
// |   count               occupancy                                            |
// | Config      : INSTR_DECODE_Q_ILLEGAL_DET_EN - store an err bit per entry   |
// |               and stop accepting after any illegal opcode until flush.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module instr_decode_q
    import instr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IMM_W = 16
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            in_instr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             out_type,
    output logic [4:0]             out_opcode,
    output logic [2:0]             out_rs,
    output logic [2:0]             out_rt,
    output logic [2:0]             out_rd,
    output logic [IMM_W-1:0]       out_imm,
    output logic                   out_err,
    output logic                   halted,
    output logic [$clog2(DEPTH):0] count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // ---------------------------------------------------------------- decode
    cls_e             dec_cls;
    logic [4:0]       dec_opcode;
    logic [2:0]       dec_rs;
    logic [2:0]       dec_rt;
    logic [2:0]       dec_rd;
    logic [IMM_W-1:0] dec_imm;
    logic             dec_illegal;
    fields_t          wr_fields;

    instr_fields_dec #(
        .IMM_W (IMM_W)
    ) u_fields_dec (
        .instr   (in_instr),
        .cls     (dec_cls),
        .opcode  (dec_opcode),
        .rs      (dec_rs),
        .rt      (dec_rt),
        .rd      (dec_rd),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    assign wr_fields = '{cls: dec_cls, opcode: dec_opcode,
                         rs: dec_rs, rt: dec_rt, rd: dec_rd};

    // ---------------------------------------------------------------- state
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             halted_q, halted_d;
    logic             full;
    logic             blocked;
    logic             push;
    logic             pop;

    fields_t          fields_mem_q [DEPTH];
    logic [IMM_W-1:0] imm_mem_q    [DEPTH];

`ifdef INSTR_DECODE_Q_ILLEGAL_DET_EN
    logic             err_mem_q [DEPTH];
    logic             err_seen_q, err_seen_d;

    assign blocked = halted_q | err_seen_q;
`else
    // Illegal opcodes are indistinguishable from class 0 in this build
    logic             unused_illegal;

    assign unused_illegal = dec_illegal;
    assign blocked        = halted_q;
`endif

    assign full     = (count_q == FULL_CNT);
    // Only registered state and flush feed in_ready; out_ready never does,
    // so a full queue does not accept even when the head is being popped.
    assign in_ready = !full && !blocked && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        halted_d = halted_q;
`ifdef INSTR_DECODE_Q_ILLEGAL_DET_EN
        err_seen_d = err_seen_q;
`endif
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            halted_d = 1'b0;
`ifdef INSTR_DECODE_Q_ILLEGAL_DET_EN
            err_seen_d = 1'b0;
`endif
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (dec_opcode == OP_HALT) begin
                    halted_d = 1'b1;
                end
`ifdef INSTR_DECODE_Q_ILLEGAL_DET_EN
                if (dec_illegal) begin
                    err_seen_d = 1'b1;
                end
`endif
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
`ifdef INSTR_DECODE_Q_ILLEGAL_DET_EN
            err_seen_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
`ifdef INSTR_DECODE_Q_ILLEGAL_DET_EN
            err_seen_q <= err_seen_d;
`endif
        end
    end

    // Storage has no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            fields_mem_q[wr_ptr_q] <= wr_fields;
            imm_mem_q[wr_ptr_q]    <= dec_imm;
`ifdef INSTR_DECODE_Q_ILLEGAL_DET_EN
            err_mem_q[wr_ptr_q]    <= dec_illegal;
`endif
        end
    end

    // ---------------------------------------------------------------- output
    fields_t head;

    assign head       = fields_mem_q[rd_ptr_q];
    assign out_valid  = (count_q != '0);
    assign out_type   = out_valid ? head.cls    : 2'd0;
    assign out_opcode = out_valid ? head.opcode : 5'd0;
    assign out_rs     = out_valid ? head.rs     : 3'd0;
    assign out_rt     = out_valid ? head.rt     : 3'd0;
    assign out_rd     = out_valid ? head.rd     : 3'd0;
    assign out_imm    = out_valid ? imm_mem_q[rd_ptr_q] : '0;
`ifdef INSTR_DECODE_Q_ILLEGAL_DET_EN
    assign out_err    = out_valid & err_mem_q[rd_ptr_q];
`else
    assign out_err    = 1'b0;
`endif
    assign halted     = halted_q;
    assign count      = count_q;

endmodule

`default_nettype wire

// File: doc/instr_decode_q.md
INSTR_DECODE_Q -- requirements
Module: instr_decode_q

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; legal values are powers of 2 from 2 to 16.
REQ-002 SHALL have parameter IMM_W, default 16, width of the extended immediate; legal values are 11 to 32.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_instr  input  16  raw instruction word from fetch.
REQ-006 SHALL have port in_valid  input  1  in_instr is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  the queue accepts an instruction this cycle.
REQ-008 SHALL have port flush  input  1  discards all entries and clears the halt latch.
REQ-009 SHALL have port out_valid  output  1  the head entry is valid.
REQ-010 SHALL have port out_ready  input  1  the consumer takes the head entry.
REQ-011 SHALL have port out_type  output  2  format class: 0 = J/HALT/NOP, 1 = I1, 2 = I2, 3 = R.
REQ-012 SHALL have ports out_opcode  output  5, and out_rs, out_rt, out_rd  output  3 each, carrying the decoded fields.
REQ-013 SHALL have port out_imm  output  IMM_W  the extended immediate.
REQ-014 SHALL have port out_err  output  1  the head opcode is unsupported.
REQ-015 SHALL have ports halted  output  1  a HALT has been enqueued; and count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 SHALL classify opcode instr[15:11] as follows:
- Class 0: HALT 00000, NOP 00001, J 00100, JAL 00110.
- Class 1: 01000-01011, 10000, 10001, 10011, 10100-10111.
- Class 2: 11000, 10010, 00101, 00111, 01100-01111.
- Class 3: 11001, 11010, 11011, 11100-11111.
- Any other opcode: class 0.
REQ-017 SHALL extract the immediate by class:
- J and JAL: instr[10:0], sign-extended.
- Class 1: instr[4:0], sign-extended for 01000, 01001, 10000, 10001, 10011; zero-extended for all other class-1 opcodes.
- Class 2: instr[7:0], zero-extended for SLBI 10010; sign-extended for all other class-2 opcodes.
- HALT, NOP and class 3: immediate is 0.
REQ-018 SHALL take rs = instr[10:8] and rt = instr[7:5]; rd = instr[4:2] for class 3, instr[7:5] for class 1, instr[10:8] for class 2, and 0 for class 0.
REQ-019 SHALL decode at enqueue and store the full decoded entry {type, opcode, rs, rt, rd, imm, err}.
REQ-020 SHALL drive in_ready = !full && !halted && !flush, from registered state only, with no combinational path from out_ready.
REQ-021 SHALL enqueue when in_valid && in_ready, and dequeue when out_valid && out_ready.
REQ-022 SHALL drive out_valid = (count != 0) and present the head entry directly from storage.
REQ-023 SHALL have latency of one cycle: an entry accepted into an empty queue at edge N is valid on the outputs after edge N.
REQ-024 SHALL leave count unchanged on a simultaneous enqueue and dequeue; read and write pointers SHALL wrap modulo DEPTH.
REQ-025 SHALL hold all out_* fields stable while out_valid && !out_ready.
REQ-026 SHALL set halted on the edge that enqueues a HALT; the HALT itself SHALL be queued, and no further instructions SHALL be accepted until flush or reset.
REQ-027 SHALL, on flush, set count to 0, both pointers to 0 and halted to 0 at the edge; flush SHALL take priority over any enqueue or dequeue in the same cycle.
REQ-028 SHALL drive out_* fields to 0 when out_valid = 0.

Reset
REQ-029 SHALL, on rst_n = 0 at a rising edge, set count = 0, both pointers = 0, halted = 0 and the error sticky bit = 0; storage contents are don't-care.
REQ-030 SHALL drive, during and after reset, in_ready = 1, out_valid = 0 and all out_* fields = 0; reset mid-stream SHALL discard every entry.

Configuration
REQ-031 SHALL, with INSTR_DECODE_Q_ILLEGAL_DET_EN defined, set err for any opcode not listed in REQ-016; out_err SHALL reflect the head entry's err bit, and a sticky bit set on any illegal enqueue SHALL also block in_ready until flush or reset.
REQ-032 SHALL, with INSTR_DECODE_Q_ILLEGAL_DET_EN undefined, tie out_err to 0, store no err bit, and treat illegal opcodes exactly as class 0 with immediate 0.

Structure
REQ-033 SHALL place the class encodings (CLS_J, CLS_I1, CLS_I2, CLS_R) and all opcode constants in the shared package instr_pkg.
REQ-034 SHALL implement classification and field extraction (REQ-016 to REQ-018) in a combinational sub-module instr_fields_dec, parametrised by IMM_W; the queue logic SHALL live in instr_decode_q.

Verification
REQ-035 SHALL cover this case: after reset, enqueue 0x4105 (ADDI, imm 5) with out_ready = 0 -> next cycle out_valid = 1, out_type = 1, out_imm = 0x0005, count = 1.
REQ-036 SHALL cover this case: enqueue 0x401F (ADDI, imm -1) and then 0x501F (XORI) -> out_imm = 0xFFFF, then 0x001F.
REQ-037 SHALL cover this case: DEPTH = 4, out_ready = 0, push 5 instructions -> in_ready = 0 after the 4th; the 5th is not accepted; count = 4.
REQ-038 SHALL cover this case: with count = 2, push and pop in the same cycle -> count stays 2 and FIFO order is preserved across pointer wrap.
REQ-039 SHALL cover this case: enqueue 0x0000 (HALT) followed by 0x0800 (NOP) -> halted = 1 and the NOP is rejected; then assert flush together with in_valid -> count = 0, halted = 0, nothing enqueued.
REQ-040 SHALL cover this case: with INSTR_DECODE_Q_ILLEGAL_DET_EN defined, enqueue opcode 00010 -> out_err = 1, out_type = 0, and in_ready = 0 until flush.
